// File: rtl/collatz_range_mp_if.sv
// ---------------------------------------------------------------------------
// collatz_range_mp_if
// Host-side bus of the multi-engine Collatz range tester.
//   go         host -> block  start a run (only honoured while idle)
//   start      host -> block  first value of the range
//   len        host -> block  number of values (0 or > RAM depth = full RAM)
//   rd_addr    host -> block  result RAM read address
//   busy       block -> host  run in progress
//   done       block -> host  one-cycle pulse once the last result is stored
//   rd_data    block -> host  registered result RAM read data
//   max_count  block -> host  largest step count stored this run
//   max_index  block -> host  offset from start of max_count
//   ovf        block -> host  sticky overflow/saturation flag for this run
// ---------------------------------------------------------------------------
interface collatz_range_mp_if #(
    parameter int N_WIDTH       = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int RAM_ADDR_BITS = 4
);
    logic                     go;
    logic [N_WIDTH-1:0]       start;
    logic [RAM_ADDR_BITS:0]   len;
    logic [RAM_ADDR_BITS-1:0] rd_addr;
    logic                     busy;
    logic                     done;
    logic [COUNT_WIDTH-1:0]   rd_data;
    logic [COUNT_WIDTH-1:0]   max_count;
    logic [RAM_ADDR_BITS-1:0] max_index;
    logic                     ovf;

    modport master (
        output go, start, len, rd_addr,
        input  busy, done, rd_data, max_count, max_index, ovf
    );

    modport slave (
        input  go, start, len, rd_addr,
        output busy, done, rd_data, max_count, max_index, ovf
    );
endinterface

// File: rtl/collatz_range_mp.sv
// ---------------------------------------------------------------------------
// collatz_range_mp
// Multi-engine Collatz range tester. On go, the step counts of len
// consecutive start values are computed by NUM_ENGINES parallel iterators
// and stored in a result RAM that the host reads back by address. The
// running maximum, its index and a sticky overflow flag are kept per run.
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    collatz_range_mp_if slave modport (go/start/len/rd_addr in;
//          busy/done/rd_data/max_count/max_index/ovf out)
// ---------------------------------------------------------------------------
module collatz_range_mp #(
    parameter int N_WIDTH       = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4,
    parameter int NUM_ENGINES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    collatz_range_mp_if.slave  bus
);

    localparam int NW = N_WIDTH + 2;   // iterator register width
    localparam int TW = N_WIDTH + 4;   // wide enough to hold 3n+1 of an NW value
    localparam int LW = RAM_ADDR_BITS + 1;
    localparam logic [LW-1:0]          FULL_LEN = LW'(RAM_WORDS);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
    endfunction

    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
        return ((l == '0) || (l > FULL_LEN)) ? FULL_LEN : l;
    endfunction

    // run control
    state_t                   state;
    logic [N_WIDTH-1:0]       start_q;
    logic [LW-1:0]            len_q;
    logic [LW-1:0]            next_idx;
    logic [LW-1:0]            wr_count;
    logic                     busy_q;
    logic                     done_q;
    logic                     ovf_q;
    logic [COUNT_WIDTH-1:0]   max_count_q;
    logic [RAM_ADDR_BITS-1:0] max_index_q;
    logic [COUNT_WIDTH-1:0]   rd_data_q;

    logic [COUNT_WIDTH-1:0]   mem [RAM_WORDS];

    // engines: act = iterating, fin = holding a result awaiting the write port
    logic [NUM_ENGINES-1:0]   eng_act;
    logic [NUM_ENGINES-1:0]   eng_fin;
    logic [NUM_ENGINES-1:0]   eng_ovf;
    logic [NW-1:0]            eng_n   [NUM_ENGINES];
    logic [COUNT_WIDTH-1:0]   eng_cnt [NUM_ENGINES];
    logic [RAM_ADDR_BITS-1:0] eng_tag [NUM_ENGINES];

    logic [NUM_ENGINES-1:0]   idle_v;
    logic [NUM_ENGINES-1:0]   disp_gnt;
    logic [NUM_ENGINES-1:0]   wr_gnt;
    logic [NUM_ENGINES-1:0]   step_end;
    logic [NUM_ENGINES-1:0]   step_ovf;
    logic [TW-1:0]            trip [NUM_ENGINES];
    logic                     disp_en;
    logic [N_WIDTH-1:0]       disp_val;
    logic                     wr_en;
    logic [COUNT_WIDTH-1:0]   wr_cnt;
    logic [RAM_ADDR_BITS-1:0] wr_tag;
    logic                     wr_ovf;

    always_comb begin
        idle_v   = ~(eng_act | eng_fin);
        disp_en  = (state == S_RUN) && (next_idx < len_q) && (|idle_v);
        // isolate the lowest set bit: lowest-numbered engine wins
        disp_gnt = disp_en ? (idle_v & (~idle_v + 1'b1)) : '0;
        wr_gnt   = eng_fin & (~eng_fin + 1'b1);
        wr_en    = |eng_fin;
        disp_val = start_q + N_WIDTH'(next_idx);   // wraps mod 2^N_WIDTH
        wr_cnt   = '0;
        wr_tag   = '0;
        wr_ovf   = 1'b0;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            trip[e]     = ({2'b00, eng_n[e]} << 1) + {2'b00, eng_n[e]} + TW'(1);
            // 0 and 1 both terminate, so an input of 0 cannot loop forever
            step_end[e] = eng_act[e] && (eng_n[e] <= NW'(1));
            step_ovf[e] = eng_act[e] && !step_end[e] && eng_n[e][0] &&
                          (trip[e][TW-1:TW-2] != 2'b00);
            if (wr_gnt[e]) begin
                wr_cnt = eng_cnt[e];
                wr_tag = eng_tag[e];
                wr_ovf = eng_ovf[e];
            end
        end
    end

    // engine control flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_act <= '0;
            eng_fin <= '0;
        end else begin
            for (int e = 0; e < NUM_ENGINES; e++) begin
                if (disp_gnt[e]) begin
                    eng_act[e] <= 1'b1;
                end else if (step_end[e] || step_ovf[e]) begin
                    eng_act[e] <= 1'b0;
                    eng_fin[e] <= 1'b1;
                end
                // the granted engine is idle again next cycle
                if (wr_gnt[e]) begin
                    eng_fin[e] <= 1'b0;
                end
            end
        end
    end

    // engine datapath
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_ENGINES; e++) begin
            if (disp_gnt[e]) begin
                eng_n[e]   <= {2'b00, disp_val};
                eng_cnt[e] <= '0;
                eng_tag[e] <= next_idx[RAM_ADDR_BITS-1:0];
                eng_ovf[e] <= 1'b0;
            end else if (eng_act[e] && !step_end[e]) begin
                if (step_ovf[e]) begin
                    eng_cnt[e] <= CNT_MAX;
                    eng_ovf[e] <= 1'b1;
                end else begin
                    eng_n[e]   <= eng_n[e][0] ? trip[e][NW-1:0] : (eng_n[e] >> 1);
                    eng_cnt[e] <= sat_inc(eng_cnt[e]);
                    if (eng_cnt[e] == CNT_MAX) begin
                        eng_ovf[e] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.go) begin
            start_q <= bus.start;
        end
    end

    // result RAM: one write port, one registered read port (old data on collision)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_tag] <= wr_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    // run FSM, write bookkeeping and max tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len_q       <= '0;
            next_idx    <= '0;
            wr_count    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            max_count_q <= '0;
            max_index_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (wr_en && state != S_IDLE) begin
                wr_count <= wr_count + 1'b1;
                // strict compare: on a tie the earlier write is kept
                if (wr_cnt > max_count_q) begin
                    max_count_q <= wr_cnt;
                    max_index_q <= wr_tag;
                end
                if (wr_ovf) begin
                    ovf_q <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        len_q       <= eff_len(bus.len);
                        next_idx    <= '0;
                        wr_count    <= '0;
                        max_count_q <= '0;
                        max_index_q <= '0;
                        ovf_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (disp_en) begin
                        next_idx <= next_idx + 1'b1;
                    end
                    if (next_idx == len_q) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (eng_act == '0 && eng_fin == '0 && wr_count == len_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.max_count = max_count_q;
    assign bus.max_index = max_index_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/collatz_range_mp.md
Name: collatz_range_mp

Overview:
Multi-engine Collatz range tester. On go, computes the Collatz step count for len consecutive start values using NUM_ENGINES parallel iterators. Results go into an internal result RAM, which the host reads back by address. Also tracks the running maximum count, its index and a sticky overflow flag; sits behind the lab host interface as the next generation of the single-engine range block.

Parameters:
N_WIDTH, 32, width of start value and iterator operand
COUNT_WIDTH, 16, width of each stored step count
RAM_WORDS, 16, result RAM depth (max values per run)
RAM_ADDR_BITS, 4, log2(RAM_WORDS)
NUM_ENGINES, 2, parallel Collatz iterators (1..8)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
go  in  1  start a run (sampled only when idle)
start  in  N_WIDTH  first value of the range
len  in  RAM_ADDR_BITS+1  number of values; 0 or >RAM_WORDS treated as RAM_WORDS
busy  out  1  high from cycle after accepted go until done
done  out  1  one-cycle pulse when the last result is written
rd_addr  in  RAM_ADDR_BITS  result RAM read address
rd_data  out  COUNT_WIDTH  registered read data
max_count  out  COUNT_WIDTH  largest count written this run
max_index  out  RAM_ADDR_BITS  index (offset from start) of max_count
ovf  out  1  sticky: some value overflowed or count saturated this run

Behaviour:
- Reset (async assert, sync deassert use): busy=0, done=0, rd_data=0, max_count=0, max_index=0, ovf=0, all engines idle. RAM contents not reset. Reset mid-run abandons the run with no done pulse.
- FSM IDLE -> RUN -> FLUSH -> IDLE. IDLE: go=1 latches start and effective len L, clears max_count/max_index/ovf and next_idx, then moves to RUN; busy=1 from the next cycle. go while busy is ignored.
- RUN dispatch: each cycle, the lowest-numbered idle engine with next_idx<L is loaded with value start+next_idx, computed mod 2^N_WIDTH, together with tag next_idx. At most one dispatch per cycle. When next_idx==L, move to FLUSH.
- Engine:
  - 1 iteration/cycle on an internal N_WIDTH+2-bit register: even -> n>>1; odd -> 3n+1.
  - Terminates when n==1. Inputs 0 and 1 finish with count 0 after 1 cycle.
  - Count saturates at 2^COUNT_WIDTH-1.
  - If 3n+1 exceeds N_WIDTH+2 bits, the engine stops immediately with count = all-ones and an overflow flag. Saturation also sets the overflow flag.
  - A finished engine holds its result until granted a write.
- Write arbitration: single RAM write port. Lowest-numbered finished engine wins; it writes mem[tag]<=count and becomes idle the same cycle, so it can be redispatched next cycle. Other finished engines stall.
- Max tracking: updated on each write. Replace only if count>max_count, so on a tie the earlier-written value wins. For NUM_ENGINES=1 this is the lowest index. ovf |= engine overflow flag.
- FLUSH: when all engines are idle and L results are written, pulse done=1 for one cycle, busy=0, go to IDLE. max_count, max_index and ovf hold until the next accepted go.
- Read port: separate from the write port; rd_data = mem[rd_addr] one cycle after rd_addr is presented. Allowed during a run. Read-during-write to the same address returns old data.
- Width rules: start+next_idx wraps mod 2^N_WIDTH; len is compared at RAM_ADDR_BITS+1 bits.

Test Plan:
- start=1, len=10, NUM_ENGINES=2 -> done pulse once; rd_addr 0..9 read 0,1,7,2,5,8,16,3,19,6; max_count=19, max_index=8, ovf=0.
- start=27, len=1 -> mem[0]=111, max_count=111, max_index=0; repeat with NUM_ENGINES=1 and 4, same results.
- N_WIDTH=8, start=27, len=1 -> 3n+1 exceeds 10 bits -> mem[0]=16'hFFFF, ovf=1, done pulses.
- len=0, start=100 -> 16 results written at addresses 0..15, matching a golden model; go pulsed mid-run has no effect and busy stays 1.
- rst_n low for 1 cycle while busy, start=1, len=16 -> busy=0, done never pulses, max_count=0; a new go afterwards completes normally.
- Tie check with NUM_ENGINES=1: start=12, len=2 (12->9 steps, 13->9 steps) -> max_count=9, max_index=0.
